// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
  localparam int          PC_INCR  = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    BUF  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_buffer.sv
// One-entry holding store for a fetched word that arrives while IF/ID is frozen.
module if_fetch_buffer
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              full
);

  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              full_q, full_d;

  // Clear wins so a redirect can never leave a stale word behind.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    full_d  = full_q;
    if (clear) begin
      instr_d = MIPS_NOP;
      pc4_d   = '0;
      full_d  = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= MIPS_NOP;
      pc4_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      full_q  <= full_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign full  = full_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF stage: PC register, single-outstanding instruction fetch, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble counters.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              holdPC,
  input  logic              holdIF_ID,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic [31:0]       IF_ID_Instr,
  output logic [ADDR_W-1:0] IF_ID_PC4,
  output logic              IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              pend_q, pend_d;
  logic              drop_q, drop_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  logic              req_fire;
  logic              rsp_take;
  logic              buf_load, buf_clear, buf_full;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_pc4;
  logic [ADDR_W-1:0] rsp_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:  if (req_fire) state_d = WAIT;
      WAIT: if (imem_rsp_valid) begin
              if (flush || drop_q)  state_d = REQ;
              else if (holdIF_ID)   state_d = BUF;
              else                  state_d = REQ;
            end
      BUF:  if (flush || !holdIF_ID) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  // A raised request is held (with its latched address) until accepted,
  // regardless of holdPC or a redirect that has already moved the PC.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst_n && state_q == REQ) imem_req_valid = pend_q || !holdPC;
    imem_addr = pend_q ? req_addr_q : pc_q;
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = (state_q == WAIT) && imem_rsp_valid;
  assign rsp_pc4  = fetch_pc_q + ADDR_W'(PC_INCR);

  assign buf_load  = rsp_take && !drop_q && !flush && holdIF_ID;
  assign buf_clear = flush || (state_q == BUF && !holdIF_ID);

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = imem_addr;
    pend_d     = imem_req_valid && !imem_req_ready;
    drop_d     = drop_q;

    // A fetch already marked for dropping must not advance the redirected PC.
    if (flush)                    pc_d = branch_target;
    else if (req_fire && !drop_q) pc_d = imem_addr + ADDR_W'(PC_INCR);
    if (req_fire) fetch_pc_d = imem_addr;

    if (rsp_take) drop_d = 1'b0;
    if (flush && ((state_q == REQ && imem_req_valid) ||
                  (state_q == WAIT && !imem_rsp_valid)))
      drop_d = 1'b1;
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = MIPS_NOP;
      valid_d = 1'b0;
    end else if (!holdIF_ID) begin
      if (rsp_take && !drop_q) begin
        instr_d = imem_rsp_data;
        pc4_d   = rsp_pc4;
        valid_d = 1'b1;
      end else if (state_q == BUF && buf_full) begin
        instr_d = buf_instr;
        pc4_d   = buf_pc4;
        valid_d = 1'b1;
      end else begin
        instr_d = MIPS_NOP;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      req_addr_q <= '0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      instr_q    <= MIPS_NOP;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

  if_fetch_buffer #(.ADDR_W(ADDR_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (imem_rsp_data),
    .pc4_in   (rsp_pc4),
    .instr    (buf_instr),
    .pc4      (buf_pc4),
    .full     (buf_full)
  );

  assign IF_ID_Instr = instr_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (holdPC && stall_q != 32'hFFFF_FFFF)    stall_d  = stall_q + 32'd1;
    if (!valid_q && bubble_q != 32'hFFFF_FFFF) bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: hand-computed fetch/IF-ID sequences.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        holdPC = 1'b0;
  logic        holdIF_ID = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0  = 32'h2408_0001;
  localparam logic [31:0] I1  = 32'h2409_0002;
  localparam logic [31:0] LW  = 32'h8C22_0000;
  localparam logic [31:0] I3  = 32'h0109_5020;
  localparam logic [31:0] ADD = 32'h0043_0820;
  localparam logic [31:0] I5  = 32'h3C01_1234;
  localparam logic [31:0] I6  = 32'hAC22_0004;
  localparam logic [31:0] I7  = 32'h0000_0020;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .holdPC         (holdPC),
    .holdIF_ID      (holdIF_ID),
    .flush          (flush),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IF_ID_Instr    (IF_ID_Instr),
    .IF_ID_PC4      (IF_ID_PC4),
    .IF_ID_valid    (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .bubble_cycles  (bubble_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Zero-wait fetch: accept in REQ, respond in the following WAIT cycle.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
    chk("fetch_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_req_ready = 1'b1;
    step();
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    chk("ifid_instr", IF_ID_Instr, word);
    chk("ifid_pc4", IF_ID_PC4, addr + 32'd4);
    chk("ifid_valid", {31'b0, IF_ID_valid}, 32'd1);
  endtask

  initial begin
    // Reset values
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr", IF_ID_Instr, 32'h0);
    chk("rst_pc4", IF_ID_PC4, 32'h0);
    chk("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    settle();

    // Straight-line fetches 0x0, 0x4, 0x8
    do_fetch(32'h0, I0);
    do_fetch(32'h4, I1);
    do_fetch(32'h8, LW);

    // Load-use stall: both holds for 3 cycles
    holdPC = 1'b1;
    holdIF_ID = 1'b1;
    settle();
    chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", IF_ID_Instr, LW);
      chk("stall_pc4", IF_ID_PC4, 32'hC);
      chk("stall_valid", {31'b0, IF_ID_valid}, 32'd1);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    holdPC = 1'b0;
    holdIF_ID = 1'b0;
    settle();
    do_fetch(32'hC, I3);

    // Response while IF/ID frozen goes to the buffer
    holdIF_ID = 1'b1;
    imem_req_ready = 1'b1;
    settle();
    chk("buf_req_addr", imem_addr, 32'h10);
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADD;
    step();
    imem_rsp_valid = 1'b0;
    chk("buf_hold_instr", IF_ID_Instr, I3);
    chk("buf_hold_pc4", IF_ID_PC4, 32'h10);
    chk("buf_hold_valid", {31'b0, IF_ID_valid}, 32'd1);
    chk("buf_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    chk("buf_hold_instr2", IF_ID_Instr, I3);
    holdIF_ID = 1'b0;
    settle();
    chk("buf_release_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    chk("buf_out_instr", IF_ID_Instr, ADD);
    chk("buf_out_pc4", IF_ID_PC4, 32'h14);
    chk("buf_out_valid", {31'b0, IF_ID_valid}, 32'd1);
    chk("buf_next_addr", imem_addr, 32'h14);

    // Flush while waiting: pending response dropped, redirect to 0x40
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    branch_target = 32'h40;
    step();
    flush = 1'b0;
    chk("flush_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("flush_instr", IF_ID_Instr, 32'h0);
    chk("flush_still_wait", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("drop_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("drop_instr", IF_ID_Instr, 32'h0);
    do_fetch(32'h40, I5);

    // Flush coinciding with the response: response discarded
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    branch_target = 32'h80;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBADB_AD00;
    step();
    flush = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("flush_rsp_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("flush_rsp_instr", IF_ID_Instr, 32'h0);

    // Back-pressure: request held stable, even after holdPC rises
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'h80);
      step();
    end
    holdPC = 1'b1;
    settle();
    chk("bp_hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("bp_hold_addr", imem_addr, 32'h80);
    step();
    chk("bp_hold_req_valid2", {31'b0, imem_req_valid}, 32'd1);
    chk("bp_hold_addr2", imem_addr, 32'h80);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = I6;
    step();
    imem_rsp_valid = 1'b0;
    chk("bp_instr", IF_ID_Instr, I6);
    chk("bp_pc4", IF_ID_PC4, 32'h84);
    chk("bp_holdpc_no_req", {31'b0, imem_req_valid}, 32'd0);
    holdPC = 1'b0;
    settle();
    chk("bp_resume_addr", imem_addr, 32'h84);

    // Asynchronous reset while waiting, then a late response
    holdIF_ID = 1'b1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("pre_rst_valid", {31'b0, IF_ID_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_instr", IF_ID_Instr, 32'h0);
    chk("arst_pc4", IF_ID_PC4, 32'h0);
    chk("arst_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    holdIF_ID = 1'b0;
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1234_5678;
    settle();
    chk("post_rst_addr", imem_addr, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("late_rsp_instr", IF_ID_Instr, 32'h0);
    do_fetch(32'h0, I7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- IF-stage consumer of the load-use stall interface: owns the PC register, issues instruction-memory fetches and drives the IF/ID pipeline register.
- Obeys holdPC/holdIF_ID from the hazard detection unit and branch flush from EX.
- Inserts NOP bubbles when no instruction is ready; one outstanding fetch maximum.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- holdPC  in  1  freeze PC; issue no new fetch.
- holdIF_ID  in  1  freeze IF/ID register contents.
- flush  in  1  taken branch/jump from EX; redirect.
- branch_target  in  ADDR_W  redirect address, sampled when flush=1.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  ADDR_W  fetch address.
- imem_rsp_valid  in  1  instruction returned, single-cycle pulse.
- imem_rsp_data  in  32  instruction word.
- IF_ID_Instr  out  32  instruction to ID.
- IF_ID_PC4  out  ADDR_W  fetch address + 4.
- IF_ID_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=REQ, IF_ID_Instr=32'h0 (NOP), IF_ID_PC4=0, IF_ID_valid=0, imem_req_valid=0, buffer empty, drop=0.
- States: REQ, WAIT, BUF.
- REQ:
  - imem_req_valid rises only when holdPC=0. Once high, it stays high with imem_addr stable until imem_req_ready=1, even if holdPC rises.
  - On acceptance: fetch_pc<=pc, pc<=pc+4 (mod 2^ADDR_W), go to WAIT.
- WAIT, on imem_rsp_valid:
  - drop=1: discard the word, clear drop, go to REQ.
  - holdIF_ID=1: store word and fetch_pc+4 in a one-entry buffer, go to BUF.
  - Otherwise: IF_ID <= {word, fetch_pc+4, valid=1}, go to REQ.
- BUF: when holdIF_ID=0, load IF_ID from the buffer, clear the buffer, go to REQ.
- Latency: IF_ID updates on the rsp_valid edge, giving minimum 2 cycles per instruction with a zero-wait memory.
- Bubbles: any cycle with holdIF_ID=0 and no instruction loading IF_ID sets IF_ID_Instr=0 and IF_ID_valid=0.
- holdIF_ID=1 with flush=0: IF_ID registers unchanged.
- Flush has priority over hold and over loading:
  - IF_ID_Instr<=0, IF_ID_valid<=0, pc<=branch_target, buffer cleared.
  - If a request is accepted or pending (REQ with valid high, or WAIT): drop<=1 and the old request completes normally.
  - If a response arrives in the same cycle as flush, it is discarded.
  - Next state after flush: WAIT if a request is in flight, else REQ.
- flush while holdPC=1: pc still takes branch_target.
- imem_rsp_valid outside WAIT is ignored.
- Reset mid-fetch: all state cleared, and an in-flight response after reset is ignored because the state is REQ.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds outputs stall_cycles[31:0] and bubble_cycles[31:0].
  - stall_cycles counts cycles with holdPC=1.
  - bubble_cycles counts cycles IF_ID_valid=0 after reset.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - MIPS_NOP = 32'h0000_0000.
  - PC_INCR = 4.
  - fetch_state enum {REQ, WAIT, BUF}.
- Sub-module: if_fetch_buffer, a one-entry store of {instr, pc4, full} with load, clear and read.

Test Plan:
- Reset release, ready=1, memory returns after 1 cycle -> imem_addr sequence 0x0, 0x4, 0x8. IF_ID_PC4 sequence 0x4, 0x8, 0xC, each with IF_ID_valid=1.
- holdPC=holdIF_ID=1 for 3 cycles while IF_ID holds 0x8C220000 (lw) -> IF_ID unchanged, no new imem_req_valid rise. On release, next instruction loads.
- Response 0x00430820 arrives while holdIF_ID=1 -> state BUF, IF_ID unchanged. Hold drops -> IF_ID_Instr=0x00430820 next edge.
- flush with branch_target=0x40 while in WAIT -> IF_ID_valid=0 and Instr=0. The pending response is discarded. Next imem_addr=0x40.
- imem_req_ready held 0 for 4 cycles, then holdPC rises -> imem_req_valid stays 1 and imem_addr stays stable until ready.
- rst_n pulsed low in WAIT -> all outputs return to reset values immediately. A late rsp_valid is ignored and the first fetch is RESET_PC.
